// File: rtl/biu_bus_if.sv
// Handshake and bus-control bundle between the EU/queue side and the BIU bus-cycle sequencer.
interface biu_bus_if;
  logic       eu_req;
  logic       eu_wr;
  logic [2:0] eu_op;
  logic       eu_ack;
  logic       q_pop;
  logic       queue_flush;
  logic       ready;
  logic [2:0] q_count;
  logic [2:0] alu_op;
  logic       ale;
  logic       internal_rd_wr;
  logic       queue_en;
  logic       ip_en;
  logic       ip_sel;
  logic       busy;

  modport slave (
    input  eu_req, eu_wr, eu_op, q_pop, queue_flush, ready,
    output eu_ack, q_count, alu_op, ale, internal_rd_wr, queue_en, ip_en, ip_sel, busy
  );

  modport master (
    output eu_req, eu_wr, eu_op, q_pop, queue_flush, ready,
    input  eu_ack, q_count, alu_op, ale, internal_rd_wr, queue_en, ip_en, ip_sel, busy
  );
endinterface

// File: rtl/biu_bus_controller.sv
// BIU bus-cycle sequencer: T1-T2-T3-(Tw)-T4 cycles, EU-over-prefetch arbitration, queue occupancy.
// Optional BIU_WAIT_STATE_EN: honour ready and insert Tw; otherwise every cycle is exactly 4 clocks.
module biu_bus_controller #(
  parameter int unsigned QUEUE_DEPTH = 6,
  parameter logic [2:0]  PREFETCH_OP = 3'b000
) (
  input  logic      clk,
  input  logic      reset,
  biu_bus_if.slave  bus
);

  typedef enum logic [2:0] {S_TI, S_T1, S_T2, S_T3, S_TW, S_T4} state_e;

  localparam logic [2:0] DEPTH = 3'(QUEUE_DEPTH);

  state_e     state_q, state_d;
  logic       cyc_eu_q, cyc_eu_d;
  logic       wr_q, wr_d;
  logic       discard_q, discard_d;
  logic [2:0] op_q, op_d;
  logic [2:0] q_count_q, q_count_d;

  logic arb_slot, grant_eu, grant_pf, kept_pf, push, pop, pf_in_flight;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_TI;
      cyc_eu_q  <= 1'b0;
      wr_q      <= 1'b0;
      discard_q <= 1'b0;
      op_q      <= 3'b000;
      q_count_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      cyc_eu_q  <= cyc_eu_d;
      wr_q      <= wr_d;
      discard_q <= discard_d;
      op_q      <= op_d;
      q_count_q <= q_count_d;
    end
  end

  // A flush arriving in T4 itself suppresses the push directly, before the discard flag could.
  assign kept_pf = (state_q == S_T4) && !cyc_eu_q && !discard_q && !bus.queue_flush;
  assign push    = kept_pf;
  assign pop     = bus.q_pop && (q_count_q != 3'd0);

  always_comb begin
    q_count_d = q_count_q;
    if (bus.queue_flush) begin
      q_count_d = 3'd0;
    end else begin
      q_count_d = q_count_q + {2'b00, push} - {2'b00, pop};
    end
  end

  // The EU request is still high during its own ack cycle, so it must not re-grant there.
  assign arb_slot = (state_q == S_TI) || (state_q == S_T4);
  assign grant_eu = arb_slot && bus.eu_req && !((state_q == S_T4) && cyc_eu_q);
  assign grant_pf = arb_slot && !grant_eu && !bus.queue_flush && (q_count_d < DEPTH);

  assign pf_in_flight = !cyc_eu_q && ((state_q == S_T1) || (state_q == S_T2) ||
                                      (state_q == S_T3) || (state_q == S_TW));

  always_comb begin
    state_d   = state_q;
    cyc_eu_d  = cyc_eu_q;
    wr_d      = wr_q;
    op_d      = op_q;
    discard_d = discard_q;

    case (state_q)
      S_TI: if (grant_eu || grant_pf) state_d = S_T1;
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
`ifdef BIU_WAIT_STATE_EN
      S_T3: state_d = bus.ready ? S_T4 : S_TW;
      S_TW: state_d = bus.ready ? S_T4 : S_TW;
`else
      S_T3: state_d = S_T4;
      S_TW: state_d = S_T4;
`endif
      S_T4: begin
        state_d   = (grant_eu || grant_pf) ? S_T1 : S_TI;
        discard_d = 1'b0;
      end
      default: state_d = S_TI;
    endcase

    if (grant_eu) begin
      cyc_eu_d = 1'b1;
      wr_d     = bus.eu_wr;
      op_d     = bus.eu_op;
    end else if (grant_pf) begin
      cyc_eu_d = 1'b0;
      wr_d     = 1'b0;
      op_d     = PREFETCH_OP;
    end

    if (bus.queue_flush && pf_in_flight) discard_d = 1'b1;
  end

  assign bus.busy           = (state_q != S_TI);
  assign bus.ale            = (state_q == S_T1);
  assign bus.internal_rd_wr = cyc_eu_q && wr_q &&
                              ((state_q == S_T2) || (state_q == S_T3) ||
                               (state_q == S_TW) || (state_q == S_T4));
  assign bus.eu_ack         = (state_q == S_T4) && cyc_eu_q;
  assign bus.queue_en       = kept_pf;
  assign bus.ip_en          = kept_pf || bus.queue_flush;
  assign bus.ip_sel         = kept_pf;
  assign bus.alu_op         = op_q;
  assign bus.q_count        = q_count_q;

endmodule
